// File: rtl/alu_ctrl_dm.sv
// ---------------------------------------------------------------------------
// alu_ctrl_dm
// Single-cycle MIPS-I datapath slice: instruction decode, 32-bit ALU,
// immediate extension and a 1024 x 32-bit little-endian data memory.
// Decode, ALU, extension and memory read are combinational. Only memory
// writes (and the reset clear of the memory) happen on the clock edge.
//
// Ports
//   clk        rising-edge clock for the data memory
//   rst        synchronous active-high reset, clears every memory word
//   ins        current instruction word (MIPS-I encoding)
//   busA       register rs value
//   busB       register rt value
//   branch     conditional branch or regimm instruction
//   jump       j, jal, jr or jalr
//   regDst     destination register comes from the rd field
//   regWr      instruction writes the register file
//   link       instruction writes a return address (jal, jalr)
//   aluResult  ALU result, also the memory address for loads and stores
//   zero       high when aluResult is zero
//   dmOut      load data, byte/half selected and extended per opcode
//   wbData     register write-back value: dmOut for loads, else aluResult
// ---------------------------------------------------------------------------
module alu_ctrl_dm (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ins,
   input  logic [31:0] busA,
   input  logic [31:0] busB,
   output logic        branch,
   output logic        jump,
   output logic        regDst,
   output logic        regWr,
   output logic        link,
   output logic [31:0] aluResult,
   output logic        zero,
   output logic [31:0] dmOut,
   output logic [31:0] wbData
);

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_NOR,
      ALU_SLT,
      ALU_SLTU,
      ALU_SLL,
      ALU_SRL,
      ALU_SRA,
      ALU_SLLV,
      ALU_SRLV,
      ALU_SRAV,
      ALU_LUI
   } alu_op_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J = 6'h02;
   localparam logic [5:0] OP_JAL = 6'h03;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_BNE = 6'h05;
   localparam logic [5:0] OP_BLEZ = 6'h06;
   localparam logic [5:0] OP_BGTZ = 6'h07;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI = 6'h0a;
   localparam logic [5:0] OP_SLTIU = 6'h0b;
   localparam logic [5:0] OP_ANDI = 6'h0c;
   localparam logic [5:0] OP_ORI = 6'h0d;
   localparam logic [5:0] OP_XORI = 6'h0e;
   localparam logic [5:0] OP_LUI = 6'h0f;
   localparam logic [5:0] OP_LB = 6'h20;
   localparam logic [5:0] OP_LH = 6'h21;
   localparam logic [5:0] OP_LW = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB = 6'h28;
   localparam logic [5:0] OP_SH = 6'h29;
   localparam logic [5:0] OP_SW = 6'h2b;

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [15:0] imm;
   alu_op_t     alu_op;
   logic        use_imm;
   logic        zero_ext;
   logic        is_load;
   logic        mem_wr;
   logic [31:0] ext_imm;
   logic [31:0] operand_b;
   logic [11:0] addr;
   logic [9:0]  word_idx;
   logic [31:0] rd_word;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] mem [1024];
   logic        unused_bits;

   assign op    = ins[31:26];
   assign funct = ins[5:0];
   assign shamt = ins[10:6];
   assign imm   = ins[15:0];

   assign unused_bits = ^ins[25:16];

   // Instruction decode. Every control starts at 0 so any opcode or funct
   // not listed below falls through as a harmless no-op.
   always_comb begin
      alu_op   = ALU_ADD;
      use_imm  = 1'b0;
      zero_ext = 1'b0;
      is_load  = 1'b0;
      mem_wr   = 1'b0;
      branch   = 1'b0;
      jump     = 1'b0;
      regDst   = 1'b0;
      regWr    = 1'b0;
      link     = 1'b0;
      case (op)
         OP_RTYPE: begin
            case (funct)
               6'h21: begin alu_op = ALU_ADD;  regDst = 1'b1; regWr = 1'b1; end
               6'h23: begin alu_op = ALU_SUB;  regDst = 1'b1; regWr = 1'b1; end
               6'h24: begin alu_op = ALU_AND;  regDst = 1'b1; regWr = 1'b1; end
               6'h25: begin alu_op = ALU_OR;   regDst = 1'b1; regWr = 1'b1; end
               6'h26: begin alu_op = ALU_XOR;  regDst = 1'b1; regWr = 1'b1; end
               6'h27: begin alu_op = ALU_NOR;  regDst = 1'b1; regWr = 1'b1; end
               6'h2a: begin alu_op = ALU_SLT;  regDst = 1'b1; regWr = 1'b1; end
               6'h2b: begin alu_op = ALU_SLTU; regDst = 1'b1; regWr = 1'b1; end
               6'h00: begin alu_op = ALU_SLL;  regDst = 1'b1; regWr = 1'b1; end
               6'h02: begin alu_op = ALU_SRL;  regDst = 1'b1; regWr = 1'b1; end
               6'h03: begin alu_op = ALU_SRA;  regDst = 1'b1; regWr = 1'b1; end
               6'h04: begin alu_op = ALU_SLLV; regDst = 1'b1; regWr = 1'b1; end
               6'h06: begin alu_op = ALU_SRLV; regDst = 1'b1; regWr = 1'b1; end
               6'h07: begin alu_op = ALU_SRAV; regDst = 1'b1; regWr = 1'b1; end
               6'h08: begin jump = 1'b1; end
               6'h09: begin jump = 1'b1; link = 1'b1; regWr = 1'b1; regDst = 1'b1; end
               default: begin end
            endcase
         end
         OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
            alu_op = ALU_SUB;
            branch = 1'b1;
         end
         OP_J: begin
            jump = 1'b1;
         end
         OP_JAL: begin
            jump  = 1'b1;
            link  = 1'b1;
            regWr = 1'b1;
         end
         OP_ADDIU: begin alu_op = ALU_ADD;  use_imm = 1'b1; regWr = 1'b1; end
         OP_SLTI:  begin alu_op = ALU_SLT;  use_imm = 1'b1; regWr = 1'b1; end
         OP_SLTIU: begin alu_op = ALU_SLTU; use_imm = 1'b1; regWr = 1'b1; end
         OP_ANDI:  begin alu_op = ALU_AND;  use_imm = 1'b1; zero_ext = 1'b1; regWr = 1'b1; end
         OP_ORI:   begin alu_op = ALU_OR;   use_imm = 1'b1; zero_ext = 1'b1; regWr = 1'b1; end
         OP_XORI:  begin alu_op = ALU_XOR;  use_imm = 1'b1; zero_ext = 1'b1; regWr = 1'b1; end
         OP_LUI:   begin alu_op = ALU_LUI;  use_imm = 1'b1; zero_ext = 1'b1; regWr = 1'b1; end
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
            alu_op  = ALU_ADD;
            use_imm = 1'b1;
            is_load = 1'b1;
            regWr   = 1'b1;
         end
         OP_SB, OP_SH, OP_SW: begin
            alu_op  = ALU_ADD;
            use_imm = 1'b1;
            mem_wr  = 1'b1;
         end
         default: begin end
      endcase
   end

   assign ext_imm   = zero_ext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
   assign operand_b = use_imm ? ext_imm : busB;

   // ALU. Shifts always act on busB; the fixed forms take the amount from
   // the shamt field and the variable forms from busA[4:0]. LUI ignores
   // busA and simply moves the immediate into the upper half.
   always_comb begin
      aluResult = '0;
      case (alu_op)
         ALU_ADD:  aluResult = busA + operand_b;
         ALU_SUB:  aluResult = busA - operand_b;
         ALU_AND:  aluResult = busA & operand_b;
         ALU_OR:   aluResult = busA | operand_b;
         ALU_XOR:  aluResult = busA ^ operand_b;
         ALU_NOR:  aluResult = ~(busA | operand_b);
         ALU_SLT:  aluResult = {31'b0, $signed(busA) < $signed(operand_b)};
         ALU_SLTU: aluResult = {31'b0, busA < operand_b};
         ALU_SLL:  aluResult = busB << shamt;
         ALU_SRL:  aluResult = busB >> shamt;
         ALU_SRA:  aluResult = $unsigned($signed(busB) >>> shamt);
         ALU_SLLV: aluResult = busB << busA[4:0];
         ALU_SRLV: aluResult = busB >> busA[4:0];
         ALU_SRAV: aluResult = $unsigned($signed(busB) >>> busA[4:0]);
         ALU_LUI:  aluResult = operand_b << 16;
         default:  aluResult = '0;
      endcase
   end

   assign zero = (aluResult == 32'h0000_0000);

   assign addr     = aluResult[11:0];
   assign word_idx = addr[11:2];
   assign rd_word  = mem[word_idx];
   assign rd_byte  = rd_word[{addr[1:0], 3'b000} +: 8];
   assign rd_half  = addr[1] ? rd_word[31:16] : rd_word[15:0];

   // Load data path: pick the byte or half addressed by the low address
   // bits and extend it. Non-load instructions just see the raw word.
   always_comb begin
      dmOut = rd_word;
      case (op)
         OP_LW:   dmOut = rd_word;
         OP_LH:   dmOut = {{16{rd_half[15]}}, rd_half};
         OP_LHU:  dmOut = {16'h0000, rd_half};
         OP_LB:   dmOut = {{24{rd_byte[7]}}, rd_byte};
         OP_LBU:  dmOut = {24'h000000, rd_byte};
         default: dmOut = rd_word;
      endcase
   end

   assign wbData = is_load ? dmOut : aluResult;

   // Data memory write port. Reset wipes every word so loads read zero
   // afterwards; otherwise a decoded store updates only the bytes it owns.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 1024; i++) begin
            mem[i] <= '0;
         end
      end else if (mem_wr) begin
         case (op)
            OP_SW: mem[word_idx] <= busB;
            OP_SH: begin
               if (addr[1]) begin
                  mem[word_idx][31:16] <= busB[15:0];
               end else begin
                  mem[word_idx][15:0] <= busB[15:0];
               end
            end
            OP_SB: mem[word_idx][{addr[1:0], 3'b000} +: 8] <= busB[7:0];
            default: begin end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_ctrl_dm.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl_dm
// Directed bench for alu_ctrl_dm. Each step drives an instruction and its
// operands, pushes the values it expects onto a scoreboard queue, and the
// queue is drained against the DUT outputs once they have settled.
// ---------------------------------------------------------------------------
module tb_alu_ctrl_dm;

   typedef enum logic [2:0] {F_ALU, F_ZERO, F_CTRL, F_DM, F_WB} field_t;

   typedef struct {
      string       tag;
      field_t      field;
      logic [31:0] expected;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] ins;
   logic [31:0] busA;
   logic [31:0] busB;
   logic        branch;
   logic        jump;
   logic        regDst;
   logic        regWr;
   logic        link;
   logic [31:0] aluResult;
   logic        zero;
   logic [31:0] dmOut;
   logic [31:0] wbData;

   exp_t        scoreboard[$];
   int          checks;
   int          errors;

   alu_ctrl_dm dut (
      .clk       (clk),
      .rst       (rst),
      .ins       (ins),
      .busA      (busA),
      .busB      (busB),
      .branch    (branch),
      .jump      (jump),
      .regDst    (regDst),
      .regWr     (regWr),
      .link      (link),
      .aluResult (aluResult),
      .zero      (zero),
      .dmOut     (dmOut),
      .wbData    (wbData)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] rtype(input logic [5:0] funct, input logic [4:0] shamt);
      return {6'h00, 5'd1, 5'd2, 5'd3, shamt, funct};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
      return {op, 5'd1, 5'd2, imm};
   endfunction

   function automatic logic [31:0] ctrl(input logic b, input logic j, input logic rd,
                                        input logic rw, input logic l);
      return {27'b0, b, j, rd, rw, l};
   endfunction

   task automatic pushExp(input string tag, input field_t field, input logic [31:0] value);
      exp_t e;
      e.tag      = tag;
      e.field    = field;
      e.expected = value;
      scoreboard.push_back(e);
   endtask

   // Drive inputs just after a falling edge, well away from the rising edge.
   task automatic applyStimulus(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      ins  = i;
      busA = a;
      busB = b;
   endtask

   // Let combinational outputs settle, then drain the scoreboard.
   task automatic checkOutput();
      exp_t        e;
      logic [31:0] observed;
      #1;
      while (scoreboard.size() > 0) begin
         e = scoreboard.pop_front();
         case (e.field)
            F_ALU:   observed = aluResult;
            F_ZERO:  observed = {31'b0, zero};
            F_CTRL:  observed = {27'b0, branch, jump, regDst, regWr, link};
            F_DM:    observed = dmOut;
            default: observed = wbData;
         endcase
         checks++;
         assert (observed === e.expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", e.tag, observed, e.expected);
         end
      end
   endtask

   task automatic clockEdge();
      @(posedge clk);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      ins    = '0;
      busA   = '0;
      busB   = '0;

      // Reset: memory cleared, combinational outputs live during reset.
      applyStimulus(itype(6'h23, 16'h0004), 32'h10, 32'h0);
      clockEdge();
      clockEdge();
      applyStimulus(itype(6'h23, 16'h0004), 32'h10, 32'h0);
      pushExp("reset_lw_dm", F_DM, 32'h0);
      pushExp("reset_lw_alu", F_ALU, 32'h14);
      pushExp("reset_lw_ctrl", F_CTRL, ctrl(0, 0, 0, 1, 0));
      checkOutput();
      rst = 1'b0;

      // addu with wrap-around to zero.
      applyStimulus(32'h00221821, 32'hFFFFFFFF, 32'h1);
      pushExp("addu_alu", F_ALU, 32'h0);
      pushExp("addu_zero", F_ZERO, 32'h1);
      pushExp("addu_ctrl", F_CTRL, ctrl(0, 0, 1, 1, 0));
      pushExp("addu_wb", F_WB, 32'h0);
      checkOutput();

      // Signed vs unsigned compare.
      applyStimulus(rtype(6'h2a, 5'd0), 32'hFFFFFFFE, 32'h1);
      pushExp("slt_alu", F_ALU, 32'h1);
      pushExp("slt_zero", F_ZERO, 32'h0);
      checkOutput();
      applyStimulus(rtype(6'h2b, 5'd0), 32'hFFFFFFFE, 32'h1);
      pushExp("sltu_alu", F_ALU, 32'h0);
      checkOutput();

      // lui and ori: zero-extended immediates.
      applyStimulus(itype(6'h0f, 16'h1234), 32'hDEADBEEF, 32'h0);
      pushExp("lui_alu", F_ALU, 32'h12340000);
      pushExp("lui_ctrl", F_CTRL, ctrl(0, 0, 0, 1, 0));
      checkOutput();
      applyStimulus(itype(6'h0d, 16'h8000), 32'h0, 32'h0);
      pushExp("ori_alu", F_ALU, 32'h00008000);
      checkOutput();
      applyStimulus(itype(6'h0c, 16'h8000), 32'hFFFFFFFF, 32'h0);
      pushExp("andi_alu", F_ALU, 32'h00008000);
      checkOutput();

      // Sign-extended immediates.
      applyStimulus(itype(6'h09, 16'hFFFF), 32'h5, 32'h0);
      pushExp("addiu_alu", F_ALU, 32'h4);
      checkOutput();
      applyStimulus(itype(6'h0a, 16'hFFFF), 32'h0, 32'h0);
      pushExp("slti_alu", F_ALU, 32'h0);
      checkOutput();
      applyStimulus(itype(6'h0b, 16'hFFFF), 32'h0, 32'h0);
      pushExp("sltiu_alu", F_ALU, 32'h1);
      checkOutput();

      // Fixed shifts on busB by shamt.
      applyStimulus(rtype(6'h03, 5'd4), 32'h0, 32'h80000000);
      pushExp("sra_alu", F_ALU, 32'hF8000000);
      checkOutput();
      applyStimulus(rtype(6'h02, 5'd4), 32'h0, 32'h80000000);
      pushExp("srl_alu", F_ALU, 32'h08000000);
      checkOutput();
      applyStimulus(rtype(6'h00, 5'd31), 32'h0, 32'h3);
      pushExp("sll_alu", F_ALU, 32'h80000000);
      checkOutput();

      // Randomised R-type ops against a reference computed here.
      for (int i = 0; i < 6; i++) begin
         a = $urandom;
         b = $urandom;
         applyStimulus(rtype(6'h21, 5'd0), a, b);
         pushExp("rnd_addu", F_ALU, a + b);
         checkOutput();
         applyStimulus(rtype(6'h23, 5'd0), a, b);
         pushExp("rnd_subu", F_ALU, a - b);
         checkOutput();
         applyStimulus(rtype(6'h26, 5'd0), a, b);
         pushExp("rnd_xor", F_ALU, a ^ b);
         checkOutput();
         applyStimulus(rtype(6'h27, 5'd0), a, b);
         pushExp("rnd_nor", F_ALU, ~(a | b));
         checkOutput();
         applyStimulus(rtype(6'h24, 5'd0), a, b);
         pushExp("rnd_and", F_ALU, a & b);
         checkOutput();
         applyStimulus(rtype(6'h25, 5'd0), a, b);
         pushExp("rnd_or", F_ALU, a | b);
         checkOutput();
         applyStimulus(rtype(6'h04, 5'd0), a, b);
         pushExp("rnd_sllv", F_ALU, b << a[4:0]);
         checkOutput();
         applyStimulus(rtype(6'h06, 5'd0), a, b);
         pushExp("rnd_srlv", F_ALU, b >> a[4:0]);
         checkOutput();
         applyStimulus(rtype(6'h07, 5'd0), a, b);
         pushExp("rnd_srav", F_ALU, $unsigned($signed(b) >>> a[4:0]));
         checkOutput();
      end

      // Store a word, then read it back with every load width.
      applyStimulus(itype(6'h2b, 16'h0004), 32'h10, 32'hA1B2C3D4);
      pushExp("sw_alu", F_ALU, 32'h14);
      pushExp("sw_ctrl", F_CTRL, ctrl(0, 0, 0, 0, 0));
      checkOutput();
      clockEdge();
      applyStimulus(itype(6'h20, 16'h0000), 32'h17, 32'h0);
      pushExp("lb_dm", F_DM, 32'hFFFFFFA1);
      pushExp("lb_wb", F_WB, 32'hFFFFFFA1);
      checkOutput();
      applyStimulus(itype(6'h24, 16'h0000), 32'h17, 32'h0);
      pushExp("lbu_dm", F_DM, 32'h000000A1);
      checkOutput();
      applyStimulus(itype(6'h21, 16'h0000), 32'h16, 32'h0);
      pushExp("lh_dm", F_DM, 32'hFFFFA1B2);
      checkOutput();
      applyStimulus(itype(6'h20, 16'hFFFE), 32'h17, 32'h0);
      pushExp("lb_negimm_dm", F_DM, 32'hFFFFFFC3);
      checkOutput();

      // Byte store leaves the other bytes untouched.
      applyStimulus(itype(6'h28, 16'h0000), 32'h14, 32'h00000055);
      clockEdge();
      applyStimulus(itype(6'h23, 16'h0000), 32'h14, 32'h0);
      pushExp("lw_after_sb", F_DM, 32'hA1B2C355);
      pushExp("lw_after_sb_wb", F_WB, 32'hA1B2C355);
      checkOutput();
      applyStimulus(itype(6'h23, 16'h0000), 32'h17, 32'h0);
      pushExp("lw_ignores_low_bits", F_DM, 32'hA1B2C355);
      checkOutput();
      applyStimulus(itype(6'h25, 16'h0000), 32'h14, 32'h0);
      pushExp("lhu_low_dm", F_DM, 32'h0000C355);
      checkOutput();
      applyStimulus(itype(6'h21, 16'h0000), 32'h14, 32'h0);
      pushExp("lh_low_dm", F_DM, 32'hFFFFC355);
      checkOutput();

      // Reset for one cycle while a store is presented: memory clears and
      // the store is dropped.
      applyStimulus(itype(6'h2b, 16'h0000), 32'h14, 32'hFFFFFFFF);
      rst = 1'b1;
      clockEdge();
      applyStimulus(itype(6'h23, 16'h0000), 32'h14, 32'h0);
      rst = 1'b0;
      pushExp("lw_after_reset", F_DM, 32'h0);
      checkOutput();

      // Half store into the upper half.
      applyStimulus(itype(6'h29, 16'h0000), 32'h16, 32'h1234BEEF);
      clockEdge();
      applyStimulus(itype(6'h23, 16'h0000), 32'h14, 32'h0);
      pushExp("lw_after_sh", F_DM, 32'hBEEF0000);
      checkOutput();

      // Address bits above 11 are ignored.
      applyStimulus(itype(6'h2b, 16'h0000), 32'h00001024, 32'h12345678);
      clockEdge();
      applyStimulus(itype(6'h23, 16'h0000), 32'h24, 32'h0);
      pushExp("lw_addr_wrap", F_DM, 32'h12345678);
      checkOutput();

      // Unknown opcode must not write memory.
      applyStimulus({6'h3f, 26'h0}, 32'h24, 32'hFFFFFFFF);
      pushExp("op3f_ctrl", F_CTRL, ctrl(0, 0, 0, 0, 0));
      checkOutput();
      clockEdge();
      applyStimulus(itype(6'h23, 16'h0000), 32'h24, 32'h0);
      pushExp("op3f_no_write", F_DM, 32'h12345678);
      checkOutput();

      // Branches and jumps.
      applyStimulus(itype(6'h04, 16'h0010), 32'h7, 32'h7);
      pushExp("beq_ctrl", F_CTRL, ctrl(1, 0, 0, 0, 0));
      pushExp("beq_zero", F_ZERO, 32'h1);
      pushExp("beq_alu", F_ALU, 32'h0);
      checkOutput();
      applyStimulus(itype(6'h05, 16'h0010), 32'h9, 32'h7);
      pushExp("bne_alu", F_ALU, 32'h2);
      pushExp("bne_zero", F_ZERO, 32'h0);
      pushExp("bne_ctrl", F_CTRL, ctrl(1, 0, 0, 0, 0));
      checkOutput();
      applyStimulus(itype(6'h01, 16'h0010), 32'h1, 32'h1);
      pushExp("regimm_ctrl", F_CTRL, ctrl(1, 0, 0, 0, 0));
      checkOutput();
      applyStimulus({6'h02, 26'h0000100}, 32'h0, 32'h0);
      pushExp("j_ctrl", F_CTRL, ctrl(0, 1, 0, 0, 0));
      checkOutput();
      applyStimulus({6'h03, 26'h0000100}, 32'h0, 32'h0);
      pushExp("jal_ctrl", F_CTRL, ctrl(0, 1, 0, 1, 1));
      checkOutput();
      applyStimulus(rtype(6'h08, 5'd0), 32'h0, 32'h0);
      pushExp("jr_ctrl", F_CTRL, ctrl(0, 1, 0, 0, 0));
      checkOutput();
      applyStimulus(rtype(6'h09, 5'd0), 32'h0, 32'h0);
      pushExp("jalr_ctrl", F_CTRL, ctrl(0, 1, 1, 1, 1));
      checkOutput();
      applyStimulus(rtype(6'h3f, 5'd0), 32'h0, 32'h0);
      pushExp("bad_funct_ctrl", F_CTRL, ctrl(0, 0, 0, 0, 0));
      checkOutput();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
